gomba_manager: RTL and testbench

- Owns a fixed pool of Goomba enemy slots: spawns them, advances each one per frame, squashes them on stomp, and frees them after a squash timeout.
- Sits between game logic (spawn and stomp events) and the colour mapper, which consumes per-pixel hit and slot-id outputs.
- Per-frame motion update is time-multiplexed: one shared position adder serves all slots, one slot per Clk cycle.

---
 rtl/gomba_manager.sv | 210 +++++++++++++++++++++
 tb/tb_gomba_manager.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gomba_manager.sv
// Goomba slot pool: spawn, per-frame motion sweep (one slot per cycle), stomp/squash timeout, pixel hit test.
// Optional feature macro GOMBA_SCORE_EN adds a saturating 16-bit stomp score output.
module gomba_manager #(
  parameter int NUM_SLOTS     = 4,
  parameter int SIZE          = 32,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 639,
  parameter int STEP          = 1,
  parameter int SQUASH_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       spawn_req,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic       spawn_dir,
  output logic       spawn_ack,
  output logic       spawn_full,
  input  logic       stomp_valid,
  input  logic [2:0] stomp_slot,
  output logic       Is_Gomba,
  output logic [2:0] gomba_id,
  output logic       gomba_squashed,
  output logic [3:0] active_count,
`ifdef GOMBA_SCORE_EN
  output logic [15:0] score,
`endif
  output logic       busy
);
  localparam int SW = 3;
  localparam int CW = (SQUASH_FRAMES > 1) ? $clog2(SQUASH_FRAMES) : 1;
  localparam logic [10:0] X_RIGHT = 11'(X_MAX - SIZE + 1);
  localparam logic [10:0] X_LEFT  = 11'(X_MIN + STEP);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] SIZE_W  = 11'(SIZE);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        idx_q, idx_d;
  logic                 fc_meta_q, fc_meta_d, fc_sync_q, fc_sync_d, tick_q, tick_d;
  logic [NUM_SLOTS-1:0] active_q, active_d, squash_q, squash_d, dir_q, dir_d;
  logic [9:0]           x_q [NUM_SLOTS];
  logic [9:0]           x_d [NUM_SLOTS];
  logic [9:0]           y_q [NUM_SLOTS];
  logic [9:0]           y_d [NUM_SLOTS];
  logic [CW-1:0]        cnt_q [NUM_SLOTS];
  logic [CW-1:0]        cnt_d [NUM_SLOTS];
  logic                 ack_q, ack_d, full_q, full_d;
  logic [3:0]           count_q, count_d;
  logic                 free_found, spawn_go;
  logic [SW-1:0]        free_idx;
  logic [NUM_SLOTS-1:0] hit_vec;
`ifdef GOMBA_SCORE_EN
  logic                 stomp_ok;
  logic [15:0]          score_q, score_d;
`endif

  always_comb begin
    fc_meta_d = frame_clk;
    fc_sync_d = fc_meta_q;
    tick_d    = fc_meta_q & ~fc_sync_q;
    state_d   = state_q;
    idx_d     = idx_q;
    active_d  = active_q;
    squash_d  = squash_q;
    dir_d     = dir_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    count_d   = '0;
`ifdef GOMBA_SCORE_EN
    stomp_ok  = 1'b0;
    score_d   = score_q;
`endif
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end
    // The ack/full guard keeps a still-held request from being served twice.
    spawn_go = (state_q == S_IDLE) && !tick_q && spawn_req && !ack_q && !full_q;
    ack_d    = spawn_go && free_found;
    full_d   = spawn_go && !free_found;

    case (state_q)
      S_IDLE: begin
        if (tick_q) begin
          state_d = S_SWEEP;
          idx_d   = '0;
        end
      end
      S_SWEEP: begin
        if (idx_q == SW'(NUM_SLOTS - 1)) state_d = S_IDLE;
        else idx_d = idx_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < NUM_SLOTS; i++) begin
      count_d = count_d + 4'(active_q[i]);
      // A spawn only targets a free slot, so it can never meet an accepted stomp.
      if (ack_d && free_idx == SW'(i)) begin
        active_d[i] = 1'b1;
        squash_d[i] = 1'b0;
        dir_d[i]    = spawn_dir;
        x_d[i]      = spawn_x;
        y_d[i]      = spawn_y;
        cnt_d[i]    = '0;
      end else if (stomp_valid && stomp_slot == SW'(i) && active_q[i] && !squash_q[i]) begin
        squash_d[i] = 1'b1;
        cnt_d[i]    = '0;
`ifdef GOMBA_SCORE_EN
        stomp_ok    = 1'b1;
`endif
      end else if (state_q == S_SWEEP && idx_q == SW'(i) && active_q[i]) begin
        if (squash_q[i]) begin
          if (cnt_q[i] == CW'(SQUASH_FRAMES - 1)) begin
            active_d[i] = 1'b0;
            squash_d[i] = 1'b0;
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else if (dir_q[i]) begin
          if ({1'b0, x_q[i]} + STEP_W > X_RIGHT) dir_d[i] = 1'b0;
          else x_d[i] = x_q[i] + STEP_W[9:0];
        end else begin
          if ({1'b0, x_q[i]} < X_LEFT) dir_d[i] = 1'b1;
          else x_d[i] = x_q[i] - STEP_W[9:0];
        end
      end
    end
`ifdef GOMBA_SCORE_EN
    if (stomp_ok) score_d = (score_q > 16'd65435) ? 16'hFFFF : score_q + 16'd100;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      fc_meta_q <= 1'b0;
      fc_sync_q <= 1'b0;
      tick_q    <= 1'b0;
      active_q  <= '0;
      squash_q  <= '0;
      dir_q     <= '0;
      x_q       <= '{default: '0};
      y_q       <= '{default: '0};
      cnt_q     <= '{default: '0};
      ack_q     <= 1'b0;
      full_q    <= 1'b0;
      count_q   <= '0;
`ifdef GOMBA_SCORE_EN
      score_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fc_meta_q <= fc_meta_d;
      fc_sync_q <= fc_sync_d;
      tick_q    <= tick_d;
      active_q  <= active_d;
      squash_q  <= squash_d;
      dir_q     <= dir_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      full_q    <= full_d;
      count_q   <= count_d;
`ifdef GOMBA_SCORE_EN
      score_q   <= score_d;
`endif
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_hit
    assign hit_vec[gi] = active_q[gi]
      && ({1'b0, DrawX} >= {1'b0, x_q[gi]}) && ({1'b0, DrawX} < {1'b0, x_q[gi]} + SIZE_W)
      && ({1'b0, DrawY} >= {1'b0, y_q[gi]}) && ({1'b0, DrawY} < {1'b0, y_q[gi]} + SIZE_W);
  end

  always_comb begin
    Is_Gomba       = |hit_vec;
    gomba_id       = '0;
    gomba_squashed = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        gomba_id       = SW'(i);
        gomba_squashed = squash_q[i];
      end
    end
  end

  assign spawn_ack    = ack_q;
  assign spawn_full   = full_q;
  assign active_count = count_q;
  assign busy         = (state_q == S_SWEEP);
`ifdef GOMBA_SCORE_EN
  assign score        = score_q;
`endif
endmodule

// File: tb/tb_gomba_manager.sv
// Scoreboard bench for gomba_manager: expectations are queued by the stimulus, monitors pop and compare.
module tb_gomba_manager;
  logic       Clk, Reset, frame_clk;
  logic [9:0] DrawX, DrawY, spawn_x, spawn_y;
  logic       spawn_req, spawn_dir, spawn_ack, spawn_full, stomp_valid;
  logic [2:0] stomp_slot, gomba_id;
  logic       Is_Gomba, gomba_squashed, busy;
  logic [3:0] active_count;
`ifdef GOMBA_SCORE_EN
  logic [15:0] score;
`endif

  int total = 0;
  int bad   = 0;
  int busy_n, ack_k;

  typedef struct {string nm; int kind; int exp;} chk_t;
  chk_t chk_q[$];
  int   pulse_q[$];
  event probe_ev;

  gomba_manager dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY),
    .spawn_req(spawn_req), .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir),
    .spawn_ack(spawn_ack), .spawn_full(spawn_full),
    .stomp_valid(stomp_valid), .stomp_slot(stomp_slot),
    .Is_Gomba(Is_Gomba), .gomba_id(gomba_id), .gomba_squashed(gomba_squashed),
    .active_count(active_count),
`ifdef GOMBA_SCORE_EN
    .score(score),
`endif
    .busy(busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic int sample(int kind);
    case (kind)
      0: return int'(Is_Gomba);
      1: return int'(gomba_id);
      2: return int'(gomba_squashed);
      3: return int'(active_count);
      4: return int'(busy);
`ifdef GOMBA_SCORE_EN
      5: return int'(score);
`endif
      6: return busy_n;
      7: return ack_k;
      default: return -1;
    endcase
  endfunction

  // Status monitor: compares every queued expectation when the stimulus signals a sample point.
  initial begin
    chk_t c;
    int   act;
    forever begin
      @(probe_ev);
      while (chk_q.size() > 0) begin
        c   = chk_q.pop_front();
        act = sample(c.kind);
        total++;
        if (act != c.exp) begin
          bad++;
          $display("FAIL %s: got %0d expected %0d", c.nm, act, c.exp);
        end else begin
          $display("ok   %s = %0d", c.nm, act);
        end
      end
    end
  end

  // Pulse monitor: every spawn_ack/spawn_full pulse must match the next queued spawn outcome.
  initial begin
    int got, e;
    forever begin
      @(posedge Clk);
      #1;
      if (spawn_ack || spawn_full) begin
        got = (spawn_ack ? 1 : 0) + (spawn_full ? 2 : 0);
        total++;
        if (pulse_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: got %0d expected none", got);
        end else begin
          e = pulse_q.pop_front();
          if (got != e) begin
            bad++;
            $display("FAIL spawn_pulse: got %0d expected %0d (1=ack 2=full)", got, e);
          end else begin
            $display("ok   spawn_pulse = %0d", got);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_v(string nm, int kind, int exp);
    chk_q.push_back('{nm, kind, exp});
  endtask

  task automatic fire();
    #1;
    -> probe_ev;
    #1;
  endtask

  task automatic probe(string nm, int x, int y, int hit, int id, int sq);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    expect_v(nm, 0, hit);
    expect_v({nm, "_id"}, 1, id);
    expect_v({nm, "_sq"}, 2, sq);
    fire();
  endtask

  task automatic check_count(string nm, int exp);
    repeat (2) @(negedge Clk);
    expect_v(nm, 3, exp);
    fire();
  endtask

  task automatic spawn(int x, int y, int dir, int exp_pulse);
    bit got;
    got = 1'b0;
    @(negedge Clk);
    spawn_x   = 10'(x);
    spawn_y   = 10'(y);
    spawn_dir = dir[0];
    pulse_q.push_back(exp_pulse);
    spawn_req = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clk);
      if (spawn_ack || spawn_full) begin
        got = 1'b1;
        break;
      end
    end
    spawn_req = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL spawn_timeout: got no pulse expected %0d", exp_pulse);
      void'(pulse_q.pop_back());
    end
  endtask

  task automatic frames(int n);
    for (int f = 0; f < n; f++) begin
      @(negedge Clk);
      frame_clk = 1'b1;
      repeat (8) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
    end
  endtask

  task automatic stomp(int s);
    @(negedge Clk);
    stomp_valid = 1'b1;
    stomp_slot  = 3'(s);
    @(negedge Clk);
    stomp_valid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; DrawX = '0; DrawY = '0;
    spawn_req = 1'b0; spawn_x = '0; spawn_y = '0; spawn_dir = 1'b0;
    stomp_valid = 1'b0; stomp_slot = '0; busy_n = 0; ack_k = 0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // Reset state
    @(negedge Clk);
    expect_v("rst_busy", 4, 0);
    expect_v("rst_count", 3, 0);
`ifdef GOMBA_SCORE_EN
    expect_v("rst_score", 5, 0);
`endif
    fire();
    probe("rst_hit", 100, 400, 0, 0, 0);

    // First spawn lands in slot 0 and walks right
    spawn(100, 400, 1, 1);
    check_count("count_1", 1);
    probe("a_at_100", 100, 400, 1, 0, 0);
    probe("a_left_99", 99, 400, 0, 0, 0);
    frames(3);
    probe("a_at_103", 103, 400, 1, 0, 0);
    probe("a_left_102", 102, 400, 0, 0, 0);
    probe("a_corner_134_431", 134, 431, 1, 0, 0);
    probe("a_right_135", 135, 400, 0, 0, 0);
    probe("a_below_432", 103, 432, 0, 0, 0);

    // Spawn raised while frame_tick is high: the sweep runs first, then the spawn
    @(negedge Clk);
    frame_clk = 1'b1;
    spawn_x = 10'd607; spawn_y = 10'd100; spawn_dir = 1'b1;
    repeat (2) @(negedge Clk);
    pulse_q.push_back(1);
    spawn_req = 1'b1;
    busy_n = 0;
    ack_k  = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (busy) busy_n++;
      if (spawn_ack && ack_k == 0) begin
        ack_k = k;
        spawn_req = 1'b0;
      end
    end
    spawn_req = 1'b0;
    frame_clk = 1'b0;
    expect_v("collide_busy_cycles", 6, 4);
    expect_v("collide_ack_cycle", 7, 6);
    fire();
    check_count("count_2", 2);
    probe("b_at_607", 607, 100, 1, 1, 0);
    probe("b_left_606", 606, 100, 0, 0, 0);

    // Right boundary: 607 -> 608, turn at 608, then back to 607
    frames(1);
    probe("b_at_608", 608, 100, 1, 1, 0);
    probe("b_not_607", 607, 100, 0, 0, 0);
    frames(1);
    probe("b_turn_608", 608, 100, 1, 1, 0);
    probe("b_turn_not_607", 607, 100, 0, 0, 0);
    frames(1);
    probe("b_back_607", 607, 100, 1, 1, 0);
    probe("b_back_638", 638, 100, 1, 1, 0);
    probe("b_back_639", 639, 100, 0, 0, 0);

    // Fill the pool, then a refused spawn
    spawn(0, 200, 0, 1);
    spawn(300, 300, 1, 1);
    check_count("count_4", 4);
    spawn(50, 50, 1, 2);
    check_count("count_full", 4);
    probe("full_no_slot", 50, 50, 0, 0, 0);

    // Left boundary: slot 2 at 0 heading left turns, then moves to 1
    frames(1);
    probe("c_turn_0", 0, 200, 1, 2, 0);
    probe("c_turn_31", 31, 200, 1, 2, 0);
    probe("c_turn_32", 32, 200, 0, 0, 0);
    frames(1);
    probe("c_not_0", 0, 200, 0, 0, 0);
    probe("c_at_1", 1, 200, 1, 2, 0);
    probe("c_at_32", 32, 200, 1, 2, 0);

    // Squash slot 2; a repeat stomp and an out-of-range stomp are ignored
    stomp(2);
    probe("sq_hit", 1, 200, 1, 2, 1);
    probe("a_walk", 109, 400, 1, 0, 0);
    frames(1);
    probe("sq_frozen_33", 33, 200, 0, 0, 0);
    probe("sq_frozen_1", 1, 200, 1, 2, 1);
    stomp(2);
    stomp(6);
    frames(28);
    probe("sq_frame29", 1, 200, 1, 2, 1);
    check_count("count_sq29", 4);
    frames(1);
    probe("sq_freed", 1, 200, 0, 0, 0);
    check_count("count_freed", 3);
    stomp(2);
    check_count("count_stomp_free", 3);
    probe("stomp_free_hit", 1, 200, 0, 0, 0);

    // Reuse freed slot 2 overlapping slot 0 (at 139): lowest index wins
    spawn(120, 400, 1, 1);
    check_count("count_reuse", 4);
    probe("overlap_140", 140, 410, 1, 0, 0);
    probe("only_f_125", 125, 410, 1, 2, 0);
    stomp(0);
    probe("overlap_sq0", 140, 410, 1, 0, 1);
`ifdef GOMBA_SCORE_EN
    @(negedge Clk);
    expect_v("score_200", 5, 200);
    fire();
`endif

    // Reset in the idx = 2 cycle of a sweep
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (5) @(negedge Clk);
    expect_v("pre_rst_busy", 4, 1);
    fire();
    Reset = 1'b1;
    frame_clk = 1'b0;
    @(negedge Clk);
    DrawX = 10'd140;
    DrawY = 10'd410;
    expect_v("mid_rst_busy", 4, 0);
    expect_v("mid_rst_count", 3, 0);
    expect_v("mid_rst_hit", 0, 0);
    fire();
    Reset = 1'b0;
    probe("post_rst_b", 575, 100, 0, 0, 0);
    probe("post_rst_d", 332, 300, 0, 0, 0);
`ifdef GOMBA_SCORE_EN
    @(negedge Clk);
    expect_v("post_rst_score", 5, 0);
    fire();
`endif

    repeat (3) @(negedge Clk);
    total++;
    if (pulse_q.size() != 0) begin
      bad++;
      $display("FAIL pending_pulses: got %0d outstanding expected 0", pulse_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
